// File: rtl/btn_debounce_toggle.sv
// Two-flop synchroniser plus hold-time debounce FSM for an active-low pushbutton; all outputs registered.
// Press/release accepted DEBOUNCE_CYCLES+3 edges after the raw change; no backpressure, strobes last one cycle.
module btn_debounce_toggle #(
    parameter int unsigned DEBOUNCE_CYCLES = 2500000,
    parameter int unsigned CNT_W           = 24
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       toggleBtn,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       toggle_state,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             btn_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             toggle_q, toggle_d;
    logic [7:0]       count_q, count_d;

    assign btn_s = ~sync2_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        toggle_d  = toggle_q;
        count_d   = count_q;
        case (state_q)
            RELEASED: begin
                if (btn_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = PRESSED;
                    level_d  = 1'b1;
                    press_d  = 1'b1;
                    toggle_d = ~toggle_q;
                    count_d  = count_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                // A bounce back to pressed returns without any strobe.
                if (btn_s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = RELEASED;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            toggle_q  <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            sync1_q   <= toggleBtn;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            toggle_q  <= toggle_d;
            count_q   <= count_d;
        end
    end

    assign btn_level     = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign toggle_state  = toggle_q;
    assign press_count   = count_q;

endmodule

// File: tb/tb_btn_debounce_toggle.sv
// Directed bench for btn_debounce_toggle with DEBOUNCE_CYCLES=4 (accept after 7 edges).
module tb_btn_debounce_toggle;

    logic       clk;
    logic       reset;
    logic       btn;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       toggle_state;
    logic [7:0] press_count;

    int n_vec;
    int n_err;
    int n_press;
    int n_release;
    int n_both;

    btn_debounce_toggle #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (24)
    ) dut (
        .CLOCK_50     (clk),
        .reset        (reset),
        .toggleBtn    (btn),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .toggle_state (toggle_state),
        .press_count  (press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (press_pulse) n_press++;
        if (release_pulse) n_release++;
        if (press_pulse && release_pulse) n_both++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".level"},   btn_level,     1'b0);
        chk({tag, ".press"},   press_pulse,   1'b0);
        chk({tag, ".release"}, release_pulse, 1'b0);
        chk({tag, ".toggle"},  toggle_state,  1'b0);
        chk({tag, ".count"},   press_count,   8'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    int p0;
    int r0;

    initial begin
        n_vec = 0; n_err = 0; n_press = 0; n_release = 0; n_both = 0;
        reset = 1'b1;
        btn   = 1'b1;
        tick(2);
        chk_all_zero("reset");
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            chk("idle.level", btn_level, 1'b0);
            chk("idle.count", press_count, 8'd0);
        end

        // Bounce: low 3, high 2, low 2, high 10 -- all too short to accept.
        p0 = n_press;
        btn = 1'b0; tick(3);
        btn = 1'b1; tick(2);
        btn = 1'b0; tick(2);
        btn = 1'b1; tick(10);
        chk("bounce.npress", n_press - p0, 0);
        chk("bounce.level", btn_level, 1'b0);
        chk("bounce.count", press_count, 8'd0);
        chk("bounce.toggle", toggle_state, 1'b0);

        // Clean press: first sampled low at edge 1, accepted at edge 7.
        btn = 1'b0;
        tick(6);
        chk("press.e6.pulse", press_pulse, 1'b0);
        chk("press.e6.level", btn_level, 1'b0);
        tick(1);
        chk("press.e7.pulse", press_pulse, 1'b1);
        chk("press.e7.level", btn_level, 1'b1);
        chk("press.e7.toggle", toggle_state, 1'b1);
        chk("press.e7.count", press_count, 8'd1);
        tick(1);
        chk("press.e8.pulse", press_pulse, 1'b0);
        chk("press.e8.level", btn_level, 1'b1);
        tick(12);
        chk("hold.npress", n_press, 1);

        // Release mirrors the press latency.
        r0 = n_release;
        btn = 1'b1;
        tick(6);
        chk("rel.e6.pulse", release_pulse, 1'b0);
        chk("rel.e6.level", btn_level, 1'b1);
        tick(1);
        chk("rel.e7.pulse", release_pulse, 1'b1);
        chk("rel.e7.level", btn_level, 1'b0);
        chk("rel.e7.toggle", toggle_state, 1'b1);
        chk("rel.e7.count", press_count, 8'd1);
        tick(1);
        chk("rel.e8.pulse", release_pulse, 1'b0);
        tick(12);
        chk("rel.nrelease", n_release - r0, 1);
        chk("rel.npress", n_press, 1);

        // 257 clean pairs from a fresh reset: wraps through 0 to 1.
        do_reset();
        chk("wrap.start.count", press_count, 8'd0);
        p0 = n_press;
        r0 = n_release;
        for (int i = 1; i <= 257; i++) begin
            btn = 1'b0; tick(8);
            btn = 1'b1; tick(8);
            if (i == 255) chk("wrap.255", press_count, 8'd255);
            if (i == 256) chk("wrap.256", press_count, 8'd0);
        end
        chk("wrap.count", press_count, 8'd1);
        chk("wrap.toggle", toggle_state, 1'b1);
        chk("wrap.npress", n_press - p0, 257);
        chk("wrap.nrelease", n_release - r0, 257);
        chk("wrap.both", n_both, 0);
        chk("wrap.level", btn_level, 1'b0);

        // Reset in the middle of PRESS_WAIT with the button still held.
        btn = 1'b0;
        tick(5);
        reset = 1'b1;
        tick(1);
        chk_all_zero("midrst.r1");
        tick(1);
        chk_all_zero("midrst.r2");
        reset = 1'b0;
        p0 = n_press;
        tick(6);
        chk("midrst.e6.pulse", press_pulse, 1'b0);
        chk("midrst.e6.npress", n_press - p0, 0);
        tick(1);
        chk("midrst.e7.pulse", press_pulse, 1'b1);
        chk("midrst.e7.level", btn_level, 1'b1);
        chk("midrst.e7.count", press_count, 8'd1);
        chk("midrst.e7.toggle", toggle_state, 1'b1);
        tick(1);
        chk("midrst.e8.pulse", press_pulse, 1'b0);
        chk("final.both", n_both, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
